// File: rtl/lbist_misr_pkg.sv
// Shared types and the MISR update step for the multi-lane LBIST signature block.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package lbist_misr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HASH = 2'b01,
        DONE = 2'b10
    } state_e;

    // Wide enough for any supported signature width; callers zero-extend and truncate.
    localparam int unsigned STEP_BITS = 64;

    function automatic logic [STEP_BITS-1:0] misr_step(
        input logic [STEP_BITS-1:0] sig,
        input logic [STEP_BITS-1:0] poly,
        input logic [STEP_BITS-1:0] msg,
        input int unsigned          width
    );
        logic [STEP_BITS-1:0] mask;
        logic [STEP_BITS-1:0] res;
        if (width >= STEP_BITS) begin
            mask = '1;
        end else begin
            mask = (STEP_BITS'(1) << width) - STEP_BITS'(1);
        end
        res = (sig << 1) & mask;
        if (sig[6'(width - 1)]) begin
            res = res ^ poly;
        end
        return (res ^ msg) & mask;
    endfunction

endpackage

// File: rtl/misr_lane.sv
// One lane: signature register, accepted-beat counter, ready and done generation.
// Latency: accepted beat visible in sig_o next cycle; lane_done_o includes the beat in flight.
// Backpressure: beat_rdy_o is high only while enabled and fewer than target beats accepted.
module misr_lane
    import lbist_misr_pkg::*;
#(
    parameter int unsigned               CUT_MSG_BITS   = 32,
    parameter int unsigned               SIGNATURE_BITS = 32,
    parameter int unsigned               CNT_BITS       = 6,
    parameter logic [SIGNATURE_BITS-1:0] SEED           = '0,
    parameter logic [SIGNATURE_BITS-1:0] POLY           = 32'h04C11DB7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear_i,
    input  logic                      en_i,
    input  logic [CNT_BITS-1:0]       target_i,
    input  logic                      beat_val_i,
    input  logic [CUT_MSG_BITS-1:0]   beat_msg_i,
    output logic                      beat_rdy_o,
    output logic [SIGNATURE_BITS-1:0] sig_o,
    output logic                      lane_done_o
);

    logic [SIGNATURE_BITS-1:0] sig_q;
    logic [SIGNATURE_BITS-1:0] sig_d;
    logic [CNT_BITS-1:0]       cnt_q;
    logic [CNT_BITS-1:0]       cnt_d;
    logic [SIGNATURE_BITS-1:0] msg_ext;
    logic                      accept;

    assign msg_ext    = SIGNATURE_BITS'(beat_msg_i);
    assign beat_rdy_o = en_i && (cnt_q < target_i);
    assign accept     = beat_val_i && beat_rdy_o;

    always_comb begin
        sig_d = sig_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            sig_d = SEED;
            cnt_d = '0;
        end else if (accept) begin
            sig_d = SIGNATURE_BITS'(misr_step(STEP_BITS'(sig_q), STEP_BITS'(POLY),
                                              STEP_BITS'(msg_ext), SIGNATURE_BITS));
            cnt_d = cnt_q + CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sig_q <= SEED;
            cnt_q <= '0;
        end else begin
            sig_q <= sig_d;
            cnt_q <= cnt_d;
        end
    end

    // Looks at the post-accept count so the FSM can leave HASH right after the last beat.
    assign lane_done_o = (cnt_d == target_i);
    assign sig_o       = sig_q;

endmodule

// File: rtl/lbist_misr_multi.sv
// Multi-lane LBIST MISR: per-lane signature compaction folded into one rotate-XOR signature.
// Latency: response valid the cycle after the last lane's final beat; N=0 gives DONE two cycles after start.
// Backpressure: per-lane cut_req_rdy until N beats; response held until lbist_resp_rdy.
module lbist_misr_multi
    import lbist_misr_pkg::*;
#(
    parameter int unsigned               NUM_CHANNELS        = 2,
    parameter int unsigned               CUT_MSG_BITS        = 32,
    parameter int unsigned               SIGNATURE_BITS      = 32,
    parameter int unsigned               MAX_OUTPUTS_TO_HASH = 32,
    parameter logic [SIGNATURE_BITS-1:0] SEED                = '0,
    parameter logic [SIGNATURE_BITS-1:0] POLY                = 32'h04C11DB7,
    parameter int unsigned               LBIST_MSG_BITS      = $clog2(MAX_OUTPUTS_TO_HASH)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_CHANNELS-1:0]              cut_req_val,
    input  logic [NUM_CHANNELS*CUT_MSG_BITS-1:0] cut_req_msg,
    output logic [NUM_CHANNELS-1:0]              cut_req_rdy,
    input  logic                                 lbist_req_val,
    input  logic [LBIST_MSG_BITS:0]              lbist_req_msg,
    output logic                                 lbist_req_rdy,
    output logic                                 lbist_resp_val,
    output logic [SIGNATURE_BITS-1:0]            lbist_resp_msg,
    input  logic                                 lbist_resp_rdy
);

    localparam int unsigned         CNT_BITS = LBIST_MSG_BITS + 1;
    localparam logic [CNT_BITS-1:0] MAX_CNT  = CNT_BITS'(MAX_OUTPUTS_TO_HASH);

    state_e                    state_q;
    logic [CNT_BITS-1:0]       target_q;
    logic [CNT_BITS-1:0]       req_count;
    logic                      req_rdy_q;
    logic                      resp_val_q;
    logic                      start;
    logic                      hashing;
    logic [NUM_CHANNELS-1:0]   lane_done;
    logic [SIGNATURE_BITS-1:0] lane_sig [NUM_CHANNELS];
    logic [SIGNATURE_BITS-1:0] fold;

    assign start     = (state_q == IDLE) && lbist_req_val;
    assign hashing   = (state_q == HASH);
    assign req_count = (lbist_req_msg > MAX_CNT) ? MAX_CNT : lbist_req_msg;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_lane
        misr_lane #(
            .CUT_MSG_BITS  (CUT_MSG_BITS),
            .SIGNATURE_BITS(SIGNATURE_BITS),
            .CNT_BITS      (CNT_BITS),
            .SEED          (SEED),
            .POLY          (POLY)
        ) u_lane (
            .clk        (clk),
            .reset      (reset),
            .clear_i    (start),
            .en_i       (hashing),
            .target_i   (target_q),
            .beat_val_i (cut_req_val[g]),
            .beat_msg_i (cut_req_msg[g*CUT_MSG_BITS +: CUT_MSG_BITS]),
            .beat_rdy_o (cut_req_rdy[g]),
            .sig_o      (lane_sig[g]),
            .lane_done_o(lane_done[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            target_q   <= '0;
            req_rdy_q  <= 1'b1;
            resp_val_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (lbist_req_val) begin
                        target_q  <= req_count;
                        state_q   <= HASH;
                        req_rdy_q <= 1'b0;
                    end
                end
                HASH: begin
                    if (&lane_done) begin
                        state_q    <= DONE;
                        resp_val_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (lbist_resp_rdy) begin
                        state_q    <= IDLE;
                        resp_val_q <= 1'b0;
                        req_rdy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    resp_val_q <= 1'b0;
                    req_rdy_q  <= 1'b1;
                end
            endcase
        end
    end

    function automatic logic [SIGNATURE_BITS-1:0] rotl(
        input logic [SIGNATURE_BITS-1:0] s,
        input int unsigned               amt
    );
        return (s << amt) | (s >> (SIGNATURE_BITS - amt));
    endfunction

    // Rotating each lane by its index keeps identical lane signatures from cancelling.
    always_comb begin
        fold = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            fold = fold ^ rotl(lane_sig[i], i % SIGNATURE_BITS);
        end
    end

    assign lbist_req_rdy  = req_rdy_q;
    assign lbist_resp_val = resp_val_q;
    assign lbist_resp_msg = resp_val_q ? fold : '0;

endmodule

// File: tb/tb_lbist_misr_multi.sv
// Self-checking bench for lbist_misr_multi with a polynomial-arithmetic reference model.
module tb_lbist_misr_multi;

    localparam int NC   = 2;
    localparam int CB   = 4;
    localparam int SB   = 4;
    localparam int MAXH = 4;
    localparam int LB   = $clog2(MAXH);

    logic             clk = 1'b0;
    logic             reset;
    logic [NC-1:0]    cut_req_val;
    logic [NC*CB-1:0] cut_req_msg;
    logic [NC-1:0]    cut_req_rdy;
    logic             lbist_req_val;
    logic [LB:0]      lbist_req_msg;
    logic             lbist_req_rdy;
    logic             lbist_resp_val;
    logic [SB-1:0]    lbist_resp_msg;
    logic             lbist_resp_rdy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lbist_misr_multi #(
        .NUM_CHANNELS       (NC),
        .CUT_MSG_BITS       (CB),
        .SIGNATURE_BITS     (SB),
        .MAX_OUTPUTS_TO_HASH(MAXH),
        .SEED               (4'h0),
        .POLY               (4'h3),
        .LBIST_MSG_BITS     (LB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cut_req_val   (cut_req_val),
        .cut_req_msg   (cut_req_msg),
        .cut_req_rdy   (cut_req_rdy),
        .lbist_req_val (lbist_req_val),
        .lbist_req_msg (lbist_req_msg),
        .lbist_req_rdy (lbist_req_rdy),
        .lbist_resp_val(lbist_resp_val),
        .lbist_resp_msg(lbist_resp_msg),
        .lbist_resp_rdy(lbist_resp_rdy)
    );

    // Signature as a GF(2) polynomial: multiply by x modulo x^4 + x + 1, then add the beat.
    function automatic int poly_hash(input int beats[$], input int n);
        int s;
        s = 0;
        for (int k = 0; k < n; k++) begin
            s = s * 2;
            if (s >= 16) s = (s - 16) ^ 3;
            s = s ^ beats[k];
        end
        return s;
    endfunction

    function automatic int fold_model(input int s0, input int s1);
        return s0 ^ (((s1 * 2) % 16) + (s1 / 8));
    endfunction

    task automatic run_beats(input int n, input int b0[$], input int b1[$], input int pct,
                             input bit lane1_first, input string nm, output int exp);
        int ns, c0, c1, cyc;
        bit done_f, v0, v1;
        logic [3:0] m0, m1;
        ns  = (n > MAXH) ? MAXH : n;
        exp = fold_model(poly_hash(b0, ns), poly_hash(b1, ns));
        lbist_req_val = 1'b1;
        lbist_req_msg = n[LB:0];
        @(negedge clk);
        lbist_req_val = 1'b0;
        c0 = 0; c1 = 0; cyc = 0; done_f = 1'b0;
        while (!done_f && cyc < 100) begin
            total++;
            if (lbist_resp_val !== 1'b0 || lbist_req_rdy !== 1'b0) begin
                bad++;
                $display("FAIL %s hash_flags: resp_val=%b req_rdy=%b, required 0/0 (cycle %0d)",
                         nm, lbist_resp_val, lbist_req_rdy, cyc);
            end
            total++;
            if (cut_req_rdy !== {c1 < ns, c0 < ns}) begin
                bad++;
                $display("FAIL %s lane_rdy: got %b, required %b (cycle %0d)",
                         nm, cut_req_rdy, {c1 < ns, c0 < ns}, cyc);
            end
            v0 = (c0 < ns) && !(lane1_first && c1 < ns) && ($urandom_range(99) < pct);
            v1 = (c1 < ns) && ($urandom_range(99) < pct);
            if (c0 >= ns) v0 = 1'($urandom_range(1));
            if (c1 >= ns) v1 = 1'($urandom_range(1));
            m0 = (c0 < ns) ? 4'(b0[c0]) : 4'($urandom);
            m1 = (c1 < ns) ? 4'(b1[c1]) : 4'($urandom);
            cut_req_val   = {v1, v0};
            cut_req_msg   = {m1, m0};
            lbist_req_val = 1'($urandom_range(1));
            lbist_req_msg = 3'($urandom);
            @(negedge clk);
            if (v0 && c0 < ns) c0++;
            if (v1 && c1 < ns) c1++;
            done_f = (c0 == ns) && (c1 == ns);
            cyc++;
        end
        cut_req_val   = '0;
        lbist_req_val = 1'b0;
        if (!done_f) begin
            bad++;
            $display("FAIL %s timeout: lanes accepted %0d/%0d of %0d", nm, c0, c1, ns);
        end
        total++;
        if (lbist_resp_val !== 1'b1 || lbist_resp_msg !== exp[3:0]) begin
            bad++;
            $display("FAIL %s resp: val=%b msg=%h, required val=1 msg=%h",
                     nm, lbist_resp_val, lbist_resp_msg, exp[3:0]);
        end
    endtask

    task automatic release_resp(input int hold, input int exp, input string nm);
        for (int k = 0; k < hold; k++) begin
            lbist_resp_rdy = 1'b0;
            lbist_req_val  = 1'($urandom_range(1));
            cut_req_val    = 2'($urandom);
            cut_req_msg    = 8'($urandom);
            @(negedge clk);
            total++;
            if (lbist_resp_val !== 1'b1 || lbist_resp_msg !== exp[3:0] ||
                lbist_req_rdy !== 1'b0 || cut_req_rdy !== 2'b00) begin
                bad++;
                $display("FAIL %s hold%0d: val=%b msg=%h req_rdy=%b cut_rdy=%b, required 1/%h/0/00",
                         nm, k, lbist_resp_val, lbist_resp_msg, lbist_req_rdy, cut_req_rdy, exp[3:0]);
            end
        end
        lbist_req_val  = 1'b0;
        cut_req_val    = '0;
        lbist_resp_rdy = 1'b1;
        @(negedge clk);
        lbist_resp_rdy = 1'b0;
        total++;
        if (lbist_req_rdy !== 1'b1 || lbist_resp_val !== 1'b0 ||
            lbist_resp_msg !== 4'h0 || cut_req_rdy !== 2'b00) begin
            bad++;
            $display("FAIL %s idle_return: req_rdy=%b val=%b msg=%h cut_rdy=%b, required 1/0/0/00",
                     nm, lbist_req_rdy, lbist_resp_val, lbist_resp_msg, cut_req_rdy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cut_req_val = '0; cut_req_msg = '0;
        lbist_req_val = 1'b0; lbist_req_msg = '0; lbist_resp_rdy = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (lbist_req_rdy !== 1'b1 || lbist_resp_val !== 1'b0 ||
            lbist_resp_msg !== 4'h0 || cut_req_rdy !== 2'b00) begin
            bad++;
            $display("FAIL reset_state: req_rdy=%b val=%b msg=%h cut_rdy=%b, required 1/0/0/00",
                     lbist_req_rdy, lbist_resp_val, lbist_resp_msg, cut_req_rdy);
        end
    endtask

    task automatic test_basic_fold();
        int q0[$], q1[$], exp;
        q0 = {1}; q1 = {2};
        run_beats(1, q0, q1, 100, 1'b0, "basic", exp);
        total++;
        if (lbist_resp_msg !== 4'h5) begin
            bad++;
            $display("FAIL basic_const: msg=%h, required 5", lbist_resp_msg);
        end
        release_resp(0, exp, "basic");
    endtask

    task automatic test_feedback();
        int q0[$], q1[$], exp;
        q0 = {8, 0}; q1 = {0, 0};
        run_beats(2, q0, q1, 100, 1'b0, "feedback", exp);
        total++;
        if (lbist_resp_msg !== 4'h3) begin
            bad++;
            $display("FAIL feedback_const: msg=%h, required 3", lbist_resp_msg);
        end
        release_resp(0, exp, "feedback");
    endtask

    task automatic test_uneven();
        int q0[$], q1[$], exp;
        q0 = {8, 0}; q1 = {0, 0};
        run_beats(2, q0, q1, 100, 1'b1, "uneven", exp);
        total++;
        if (lbist_resp_msg !== 4'h3) begin
            bad++;
            $display("FAIL uneven_const: msg=%h, required 3", lbist_resp_msg);
        end
        release_resp(1, exp, "uneven");
    endtask

    task automatic test_zero_count();
        int q0[$], q1[$], exp;
        run_beats(0, q0, q1, 100, 1'b0, "zero", exp);
        total++;
        if (lbist_resp_msg !== 4'h0) begin
            bad++;
            $display("FAIL zero_const: msg=%h, required 0", lbist_resp_msg);
        end
        release_resp(0, exp, "zero");
    endtask

    task automatic test_backpressure_sat();
        int q0[$], q1[$], exp;
        for (int k = 0; k < 7; k++) begin
            q0.push_back(int'($urandom_range(15)));
            q1.push_back(int'($urandom_range(15)));
        end
        run_beats(7, q0, q1, 60, 1'b0, "saturate", exp);
        release_resp(3, exp, "backpressure");
    endtask

    task automatic test_reset_mid_hash();
        int q0[$], q1[$], exp;
        lbist_req_val = 1'b1;
        lbist_req_msg = 3'd2;
        @(negedge clk);
        lbist_req_val = 1'b0;
        cut_req_val = 2'b11;
        cut_req_msg = {4'h7, 4'h9};
        @(negedge clk);
        cut_req_val = 2'b00;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (lbist_req_rdy !== 1'b1 || lbist_resp_val !== 1'b0 || cut_req_rdy !== 2'b00) begin
            bad++;
            $display("FAIL midreset_idle: req_rdy=%b val=%b cut_rdy=%b, required 1/0/00",
                     lbist_req_rdy, lbist_resp_val, cut_req_rdy);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if (lbist_resp_val !== 1'b0 || lbist_req_rdy !== 1'b1) begin
                bad++;
                $display("FAIL midreset_quiet%0d: val=%b req_rdy=%b, required 0/1",
                         k, lbist_resp_val, lbist_req_rdy);
            end
        end
        q0 = {1}; q1 = {2};
        run_beats(1, q0, q1, 100, 1'b0, "after_reset", exp);
        total++;
        if (lbist_resp_msg !== 4'h5) begin
            bad++;
            $display("FAIL after_reset_const: msg=%h, required 5", lbist_resp_msg);
        end
        release_resp(0, exp, "after_reset");
    endtask

    task automatic test_random_runs();
        for (int r = 0; r < 12; r++) begin
            int q0[$], q1[$], exp, n, pct;
            n   = int'($urandom_range(7));
            pct = int'($urandom_range(100, 30));
            for (int k = 0; k < MAXH; k++) begin
                q0.push_back(int'($urandom_range(15)));
                q1.push_back(int'($urandom_range(15)));
            end
            run_beats(n, q0, q1, pct, 1'($urandom_range(1)), "random", exp);
            release_resp(int'($urandom_range(2)), exp, "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic_fold();
        test_feedback();
        test_uneven();
        test_zero_count();
        test_backpressure_sat();
        test_reset_mid_hash();
        test_random_runs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
